// File: rtl/input_debouncer_pkg.sv
// Shared types and helpers for the input debouncer: channel FSM states,
// default debounce count and counter-width sizing.
package input_debouncer_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } ch_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Smallest width W such that 2**W > max_count.
    function automatic int min_cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce slice: 2-flop synchronizer, polarity normalisation, stable/changing
// FSM with counter, registered press/release pulses and a sticky press flag.
// Optional auto-repeat of press pulses is enabled by defining AUTO_REPEAT_EN.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic clear_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic latched_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              sync1_q;
    logic              sync2_q;
    logic              sIn;
    ch_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              latched_q;
    logic              latched_d;
    logic              rptFire;

    // Synchronizer idles at the inactive raw value so reset never looks like a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign sIn = sync2_q ^ ACTIVE_LOW;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = min_cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q;
    logic             rptArmed_q;

    assign rptFire = level_q && (rptArmed_q ? (rpt_q == PERIOD_LAST) : (rpt_q == DELAY_LAST));

    // First repeat waits REPEAT_DELAY after the accepted press, later ones REPEAT_PERIOD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q      <= '0;
            rptArmed_q <= 1'b0;
        end else if (!level_q) begin
            rpt_q      <= '0;
            rptArmed_q <= 1'b0;
        end else if (rptFire) begin
            rpt_q      <= '0;
            rptArmed_q <= 1'b1;
        end else begin
            rpt_q      <= rpt_q + RPT_W'(1);
        end
    end
`else
    assign rptFire = 1'b0;
`endif

    // Pulses are emitted on the same edge that toggles the level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= rptFire;
            release_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    cnt_q <= '0;
                    if (sIn != level_q) begin
                        state_q <= CHANGING;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                CHANGING: begin
                    if (sIn == level_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        level_q   <= ~level_q;
                        press_q   <= ~level_q;
                        release_q <= level_q;
                        cnt_q     <= '0;
                        state_q   <= STABLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Set is driven by the visible press pulse so a clear in that cycle loses.
    always_comb begin
        latched_d = press_q | (latched_q & ~clear_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latched_q <= 1'b0;
        end else begin
            latched_q <= latched_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign latched_o = latched_q;

endmodule

// File: rtl/input_debouncer.sv
// Top of the KEY/joystick conditioning stage: one debounce_channel per input,
// with per-channel polarity taken from ACTIVE_LOW_MASK. Optional macro: AUTO_REPEAT_EN.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int              N_CH            = 8,
    parameter int              DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int              CNT_W           = 20,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = 8'h0F,
    parameter int              REPEAT_DELAY    = 25000000,
    parameter int              REPEAT_PERIOD   = 5000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] press_latched,
    input  logic [N_CH-1:0] clear_latched
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (reset),
            .raw_i    (raw_in[i]),
            .clear_i  (clear_latched[i]),
            .level_o  (level_out[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .latched_o(press_latched[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer with DEBOUNCE_CYCLES=4.
// The auto-repeat scenario runs only when AUTO_REPEAT_EN is defined.
module tb_input_debouncer;

    logic       clk;
    logic       reset;
    logic [7:0] raw_in;
    logic [7:0] level_out;
    logic [7:0] press_pulse;
    logic [7:0] release_pulse;
    logic [7:0] press_latched;
    logic [7:0] clear_latched;

    int checks = 0;
    int errors = 0;

    input_debouncer #(
        .N_CH           (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (5),
        .ACTIVE_LOW_MASK(8'h0F),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw_in),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_latched(press_latched),
        .clear_latched(clear_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        raw_in        = 8'h0F;
        clear_latched = 8'h00;
        repeat (3) tick();
        checks++;
        if ({level_out, press_pulse, release_pulse, press_latched} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_state got %h expected 0",
                     {level_out, press_pulse, release_pulse, press_latched});
        end
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if ({level_out, press_pulse, release_pulse, press_latched} !== 32'h0) begin
                errors++;
                $display("[TB] FAIL idle cycle %0d got %h expected 0", k,
                         {level_out, press_pulse, release_pulse, press_latched});
            end
        end
    endtask

    task automatic test_clean_press;
        int riseAt;
        int fallAt;
        int presses;
        int releases;
        riseAt = -1; fallAt = -1; presses = 0; releases = 0;
        raw_in[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (level_out[0] && riseAt < 0) begin
                riseAt = k;
                checks++;
                if (press_pulse[0] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL press_with_level got %b expected 1", press_pulse[0]);
                end
            end
            presses += int'(press_pulse[0]);
        end
        checks++;
        if (riseAt != 5) begin
            errors++;
            $display("[TB] FAIL press_latency got %0d expected 5", riseAt);
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("[TB] FAIL press_count got %0d expected 1", presses);
        end
        checks++;
        if (press_latched[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press_latched0 got %b expected 1", press_latched[0]);
        end
        raw_in[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (release_pulse[0]) begin
                releases++;
                if (fallAt < 0) fallAt = k;
            end
        end
        checks++;
        if (fallAt != 5 || releases != 1 || level_out[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release got at=%0d n=%0d lvl=%b expected at=5 n=1 lvl=0",
                     fallAt, releases, level_out[0]);
        end
        clear_latched = 8'h01;
        tick();
        clear_latched = 8'h00;
        checks++;
        if (press_latched !== 8'h00) begin
            errors++;
            $display("[TB] FAIL clear0 got %h expected 00", press_latched);
        end
    endtask

    task automatic test_bounce;
        int riseAt;
        int presses;
        int releases;
        int events;
        events = 0;
        raw_in[4] = 1'b1;
        repeat (3) tick();
        raw_in[4] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            events += int'(level_out[4]) + int'(press_pulse[4]) + int'(release_pulse[4]);
        end
        checks++;
        if (events != 0 || press_latched[4] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch3 got events=%0d latched=%b expected 0 0",
                     events, press_latched[4]);
        end
        riseAt = -1; presses = 0; releases = 0;
        raw_in[4] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 5) raw_in[4] = 1'b0;
            if (level_out[4] && riseAt < 0) riseAt = k;
            presses  += int'(press_pulse[4]);
            releases += int'(release_pulse[4]);
        end
        checks++;
        if (riseAt != 5 || presses != 1 || releases != 1) begin
            errors++;
            $display("[TB] FAIL pulse6 got at=%0d p=%0d r=%0d expected at=5 p=1 r=1",
                     riseAt, presses, releases);
        end
        clear_latched = 8'h10;
        tick();
        clear_latched = 8'h00;
    endtask

    task automatic test_clear_race;
        raw_in[1] = 1'b0;
        repeat (6) tick();
        checks++;
        if (press_pulse[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL race_pulse got %b expected 1", press_pulse[1]);
        end
        clear_latched[1] = 1'b1;
        tick();
        clear_latched[1] = 1'b0;
        checks++;
        if (press_latched[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL race_set_wins got %b expected 1", press_latched[1]);
        end
        tick();
        checks++;
        if (press_latched[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL race_hold got %b expected 1", press_latched[1]);
        end
        clear_latched[1] = 1'b1;
        tick();
        clear_latched[1] = 1'b0;
        checks++;
        if (press_latched[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL race_clear got %b expected 0", press_latched[1]);
        end
        raw_in[1] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_mid_reset;
        int riseAt;
        int presses;
        raw_in[5] = 1'b1;
        repeat (8) tick();
        checks++;
        if (level_out[5] !== 1'b1 || press_latched[5] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prep_ch5 got lvl=%b lat=%b expected 1 1",
                     level_out[5], press_latched[5]);
        end
        raw_in[2] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #2;
        checks++;
        if ({level_out, press_pulse, release_pulse, press_latched} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset got %h expected 0",
                     {level_out, press_pulse, release_pulse, press_latched});
        end
        repeat (2) tick();
        reset = 1'b0;
        riseAt = -1; presses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (level_out[2] && riseAt < 0) riseAt = k;
            presses += int'(press_pulse[2]);
        end
        checks++;
        if (riseAt != 5 || presses != 1) begin
            errors++;
            $display("[TB] FAIL mid_reset got at=%0d p=%0d expected at=5 p=1", riseAt, presses);
        end
        checks++;
        if (level_out !== 8'h24) begin
            errors++;
            $display("[TB] FAIL redebounce_levels got %h expected 24", level_out);
        end
        raw_in = 8'h0F;
        repeat (10) tick();
        clear_latched = 8'hFF;
        tick();
        clear_latched = 8'h00;
        checks++;
        if ({level_out, press_latched} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL cleanup got %h expected 0", {level_out, press_latched});
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat;
        int pulseAt[4];
        int presses;
        int releases;
        int fallAt;
        presses = 0; releases = 0; fallAt = -1;
        raw_in[3] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 20) raw_in[3] = 1'b1;
            if (press_pulse[3]) begin
                if (presses < 4) pulseAt[presses] = k;
                presses++;
            end
            if (release_pulse[3]) begin
                releases++;
                fallAt = k;
            end
        end
        checks++;
        if (presses != 4) begin
            errors++;
            $display("[TB] FAIL repeat_count got %0d expected 4", presses);
        end else begin
            checks++;
            if (pulseAt[0] != 5 || pulseAt[1] != 15 || pulseAt[2] != 19 || pulseAt[3] != 23) begin
                errors++;
                $display("[TB] FAIL repeat_times got %0d %0d %0d %0d expected 5 15 19 23",
                         pulseAt[0], pulseAt[1], pulseAt[2], pulseAt[3]);
            end
        end
        checks++;
        if (releases != 1 || fallAt != 26) begin
            errors++;
            $display("[TB] FAIL repeat_release got n=%0d at=%0d expected n=1 at=26",
                     releases, fallAt);
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        raw_in        = 8'h0F;
        clear_latched = 8'h00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_clear_race();
        test_mid_reset();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
